// File: rtl/program_loader.sv
// Streams DEPTH instruction words into the program RAM while holding the processor in reset.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum word and an ERROR state.
module program_loader #(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic              cpu_preset,
  output logic              cpu_counter_reset,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK   = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              preset_q, preset_d;
  logic              done_q, done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q, sum_d;
  logic              error_q, error_d;
`endif

  logic xfer;
  logic last_word;

  // in_ready_q is high exactly in the states that accept words, so it doubles as the state gate.
  assign xfer      = in_valid & in_ready_q;
  assign last_word = (count_q == ADDR_W'(DEPTH - 1));

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      S_LOAD: begin
        if (xfer) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = count_q;
          ram_wdata_d = in_data;
          count_d     = count_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d       = sum_q ^ in_data;
          if (last_word) state_d = S_CHECK;
`else
          if (last_word) state_d = S_RELEASE;
`endif
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) state_d = (in_data == sum_q) ? S_RELEASE : S_ERROR;
      end

      S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
          sum_d   = '0;
        end
      end
`endif

      // One cycle so the final RAM write lands while the processor is still held.
      S_RELEASE: state_d = S_RUN;

      S_RUN: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: status outputs are decoded from the next state and registered, so they change on the
  // same edge as the state itself and never glitch.
  always_comb begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    in_ready_d = (state_d == S_LOAD) || (state_d == S_CHECK);
    error_d    = (state_d == S_ERROR);
`else
    in_ready_d = (state_d == S_LOAD);
`endif
    preset_d   = (state_d != S_RUN);
    done_d     = (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments only; the program RAM lives outside and
  // is deliberately never cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      preset_q    <= 1'b1;
      done_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      preset_q    <= preset_d;
      done_q      <= done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      error_q     <= error_d;
`endif
    end
  end

  assign in_ready          = in_ready_q;
  assign ram_we            = ram_we_q;
  assign ram_addr          = ram_addr_q;
  assign ram_wdata         = ram_wdata_q;
  assign cpu_preset        = preset_q;
  assign cpu_counter_reset = preset_q;
  assign done              = done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign error             = error_q;
`else
  assign error             = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: a word-queue model predicts every RAM write and status phase.
// Build with PROGRAM_LOADER_CHECKSUM_EN defined to also exercise the checksum/ERROR path.
module tb_program_loader;
  localparam int ADDR_W = 3;
  localparam int WORD_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic              cpu_preset;
  logic              cpu_counter_reset;
  logic              done;
  logic              error;

  program_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .ram_we            (ram_we),
    .ram_addr          (ram_addr),
    .ram_wdata         (ram_wdata),
    .cpu_preset        (cpu_preset),
    .cpu_counter_reset (cpu_counter_reset),
    .done              (done),
    .error             (error)
  );

  always #5 clk = ~clk;

  // Program RAM as the processor would see it.
  logic [WORD_W-1:0] mem [DEPTH];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  logic [WORD_W-1:0] prog [DEPTH];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [WORD_W-1:0] prog_xor();
    logic [WORD_W-1:0] x = '0;
    for (int i = 0; i < DEPTH; i++) x ^= prog[i];
    return x;
  endfunction

  task automatic check_status(input string tag, input logic rdy, input logic held,
                              input logic dn, input logic err);
    check({tag, ".in_ready"}, in_ready, rdy);
    check({tag, ".preset"}, cpu_preset, held);
    check({tag, ".counter_reset"}, cpu_counter_reset, held);
    check({tag, ".done"}, done, dn);
    check({tag, ".error"}, error, err);
  endtask

  task automatic do_start();
    start    = 1'b1;
    in_valid = 1'b0;
    step();
    start    = 1'b0;
    check_status("start", 1'b1, 1'b1, 1'b0, 1'b0);
    check("start.we", ram_we, 1'b0);
  endtask

  // mode 0: valid every cycle, 1: valid toggles, 2: random valid plus random (ignored) start.
  // Sends prog[0..DEPTH-1] then ck; returns after 'limit' accepted words.
  task automatic load(input int mode, input int limit, input logic [WORD_W-1:0] ck);
    int   sent = 0;
    int   cyc  = 0;
    logic v;
    while (sent < limit && cyc < 400) begin
      check("load.in_ready", in_ready, 1'b1);
      check("load.preset", cpu_preset, 1'b1);
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else                v = ($urandom_range(0, 2) != 0);
      in_valid = v;
      in_data  = v ? ((sent < DEPTH) ? prog[sent] : ck) : WORD_W'($urandom);
      start    = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      cyc++;
      if (v && sent < DEPTH) begin
        check("load.we", ram_we, 1'b1);
        check("load.addr", ram_addr, sent);
        check("load.wdata", ram_wdata, prog[sent]);
      end else begin
        check("load.we_idle", ram_we, 1'b0);
      end
      if (v) sent++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("load.sent", sent, limit);
  endtask

  task automatic expect_run();
    check_status("release", 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = WORD_W'($urandom);
    step();
    in_valid = 1'b0;
    check_status("run", 1'b0, 1'b0, 1'b1, 1'b0);
    check("run.we", ram_we, 1'b0);
    for (int i = 0; i < DEPTH; i++) check("run.ram", mem[i], prog[i]);
  endtask

  task automatic expect_error();
    for (int i = 0; i < 3; i++) begin
      check_status("error", 1'b0, 1'b1, 1'b0, 1'b1);
      in_valid = 1'b1;
      in_data  = WORD_W'($urandom);
      step();
      check("error.we", ram_we, 1'b0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    check_status("reset", 1'b0, 1'b1, 1'b0, 1'b0);
    check("reset.we", ram_we, 1'b0);
    check("reset.addr", ram_addr, 0);
    check("reset.wdata", ram_wdata, 0);

    // Valid words in IDLE must not transfer.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 4'h5;
    step();
    step();
    check_status("idle", 1'b0, 1'b1, 1'b0, 1'b0);
    check("idle.we", ram_we, 1'b0);
    in_valid = 1'b0;

    // Back-to-back 0x1..0x8.
    for (int i = 0; i < DEPTH; i++) prog[i] = WORD_W'(i + 1);
    do_start();
    load(0, DEPTH + CK, prog_xor());
    expect_run();

    // Reload from RUN with valid toggling, alternating 0xA/0x3.
    for (int i = 0; i < DEPTH; i++) prog[i] = (i % 2 == 0) ? 4'hA : 4'h3;
    do_start();
    load(1, DEPTH + CK, prog_xor());
    expect_run();

    // Reset after 4 words, with a valid word offered on the reset edge.
    for (int i = 0; i < DEPTH; i++) prog[i] = WORD_W'($urandom);
    do_start();
    load(2, 4, 4'h0);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = WORD_W'($urandom);
    step();
    check_status("midreset", 1'b0, 1'b1, 1'b0, 1'b0);
    check("midreset.we", ram_we, 1'b0);
    check("midreset.addr", ram_addr, 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    step();
    check_status("midreset.idle", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) prog[i] = 4'hF;
    do_start();
    load(0, DEPTH + CK, prog_xor());
    expect_run();

    // Reset and start together: reset wins, loader stays idle.
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    check_status("rst_start", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_status("rst_start.idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // Random programs with random handshakes.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < DEPTH; i++) prog[i] = WORD_W'($urandom);
      do_start();
      load(2, DEPTH + CK, prog_xor());
      expect_run();
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    for (int i = 0; i < DEPTH; i++) prog[i] = WORD_W'(i + 1);
    do_start();
    load(0, DEPTH + 1, 4'h8);
    expect_run();

    do_start();
    load(0, DEPTH + 1, 4'h0);
    expect_error();
    do_start();
    load(2, DEPTH + 1, prog_xor());
    expect_run();

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < DEPTH; i++) prog[i] = WORD_W'($urandom);
      do_start();
      load(2, DEPTH + 1, prog_xor() ^ WORD_W'($urandom_range(1, 15)));
      expect_error();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the simplest2 processor.
- Accepts instruction words over a valid/ready stream and writes them into the 8-entry program RAM.
- Holds the processor in reset (preset plus counter_ram8_reset) while loading, then releases it to run.
- Lets the bench or a host load a new program without hand-editing RAM contents.

Parameters:
ADDR_W, 3, program RAM address width; DEPTH = 2**ADDR_W words (default 8)
WORD_W, 4, instruction word width

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to begin a (re)load
in_data  input  WORD_W  instruction word
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a word this cycle
ram_we  output  1  program RAM write strobe
ram_addr  output  ADDR_W  program RAM write address
ram_wdata  output  WORD_W  program RAM write data
cpu_preset  output  1  drives processor preset
cpu_counter_reset  output  1  drives processor counter_ram8_reset
done  output  1  program loaded, processor running
error  output  1  checksum mismatch (0 when CHECKSUM_EN is undefined)

Behaviour:
- Clocking and reset:
  - Single clock, clk. Reset is synchronous and active-high on port reset, sampled on the rising edge.
  - All outputs are registered.
- Reset values: state=IDLE, in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, cpu_preset=1, cpu_counter_reset=1, done=0, error=0, word count=0.
- States: IDLE, LOAD, RELEASE, RUN, plus CHECK and ERROR when CHECKSUM_EN is defined.
- IDLE:
  - Processor held in reset; in_ready=0.
  - start=1 -> LOAD next cycle; count cleared to 0.
- LOAD:
  - in_ready=1.
  - Transfer occurs when in_valid & in_ready are both high at a rising edge.
  - A transfer at edge N gives ram_we=1, ram_addr=count, ram_wdata=in_data during cycle N+1. Write latency is 1 cycle.
  - count increments per transfer.
  - The transfer with count==DEPTH-1 moves to RELEASE (or CHECK); in_ready drops in the same cycle.
  - ram_we is 0 on non-transfer cycles; ram_addr/ram_wdata hold their last value.
  - in_valid while not in LOAD is ignored (no transfer).
  - start in LOAD is ignored.
- RELEASE:
  - Exactly one cycle, so the final write commits while the processor is still in reset.
  - cpu_preset and cpu_counter_reset stay 1.
- RUN:
  - cpu_preset=0, cpu_counter_reset=0, done=1 from the first RUN cycle.
  - start=1 -> LOAD next cycle: resets reassert, done=0, count=0 (reload).
- Address wrap: count is ADDR_W bits and is never allowed to wrap inside LOAD. Exactly DEPTH words are accepted per load.
- Reset mid-load: returns to IDLE next edge, with reset values applied.
  - Partially written RAM contents are not cleared.
  - ram_we is 0 on the cycle after reset.
- Simultaneous reset and start: reset wins.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN
- Defined:
  - A running XOR of all DEPTH accepted words is kept; it is cleared on entry to LOAD.
  - After the last word, the state is CHECK, with in_ready=1 and one extra word accepted (not written to RAM; ram_we=0).
  - Accepted word equals the XOR -> RELEASE.
  - Mismatch -> ERROR: error=1, processor held in reset, done=0. Only start (-> LOAD, error cleared) or reset leaves ERROR.
- Undefined: no CHECK or ERROR state; error tied to 0; RELEASE follows the last word directly.

Test Plan:
- Reset held 2 cycles, then released -> cpu_preset=1, cpu_counter_reset=1, done=0, in_ready=0, ram_we=0.
- start pulse, then 8 back-to-back words 0x1,0x2,...,0x8 with in_valid=1 ->
  - 8 consecutive ram_we pulses with addr 0..7 and data 0x1..0x8;
  - one RELEASE cycle;
  - then cpu_preset=0, cpu_counter_reset=0, done=1.
- Words 0xA,0x3 with in_valid toggling 1/0 each cycle -> ram_we only on the cycle after each accepted word; addr advances only on transfers; 8 words still required.
- Reset asserted after 4 of 8 words -> IDLE next edge, processor in reset; a following start reload writes again from addr 0.
- In RUN, assert start -> resets reassert and done=0 next cycle; a full reload of 0xF x8 reaches RUN again.
- PROGRAM_LOADER_CHECKSUM_EN:
  - Words 0x1..0x8 with checksum 0x8 (XOR of 1..8) -> RUN.
  - Same words with checksum 0x0 -> error=1, processor stays in reset until start.
